// File: rtl/srp_pq_pkg.sv
// pq_pkg: shared operation encoding and key ranking for the priority-queue family
package pq_pkg;
  typedef enum logic [1:0] {OP_NONE, OP_ENQ, OP_DEQ, OP_REPL} op_t;
  localparam int RANK_BITS = 32;
  function automatic logic rank_before(input logic [RANK_BITS-1:0] a, input logic [RANK_BITS-1:0] b, input logic max_first);
    return max_first ? (a > b) : (a < b);
  endfunction
endpackage

// File: rtl/srp_pq_cell.sv
// srp_cell: one sorted-array slot choosing hold / take left / take right / take kvi
module srp_cell
  import pq_pkg::*;
#(
  parameter int KEY_BITS  = 8,
  parameter int VAL_BITS  = 8,
  parameter bit MAX_FIRST = 1'b0,
  parameter bit FIRST     = 1'b0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  op_t                          op,
  input  logic [KEY_BITS+VAL_BITS-1:0] kvi,
  input  logic [KEY_BITS+VAL_BITS:0]   left,
  input  logic [KEY_BITS+VAL_BITS:0]   right,
  output logic [KEY_BITS+VAL_BITS:0]   cur
);
  localparam int W = KEY_BITS + VAL_BITS + 1;
  logic ins_l, ins_s, ins_r;
  logic [W-1:0] nxt;
  // an empty slot is always outranked; equal keys are not, so ties stay FIFO
  function automatic logic ins(input logic [W-1:0] e);
    return !e[W-1] || rank_before(RANK_BITS'(kvi[W-2 -: KEY_BITS]), RANK_BITS'(e[W-2 -: KEY_BITS]), MAX_FIRST);
  endfunction
  // replace views the array as already shifted left, so it uses the right/self pair
  always_comb begin
    ins_l = ins(left);
    ins_s = ins(cur);
    ins_r = ins(right);
    nxt = op == OP_ENQ  ? (ins_s ? ((FIRST || !ins_l) ? {1'b1, kvi} : left) : cur) :
          op == OP_DEQ  ? right :
          op == OP_REPL ? (ins_r ? ((FIRST || !ins_s) ? {1'b1, kvi} : cur) : right) :
          cur;
  end
  // slot register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cur <= '0;
    else cur <= nxt;
endmodule

// File: rtl/srp_pq.sv
// srp_pq: shift-register priority queue with min/max ordering and FIFO ties
module srp_pq
  import pq_pkg::*;
#(
  parameter int KEY_BITS  = 8,
  parameter int VAL_BITS  = 8,
  parameter int DEPTH     = 8,
  parameter bit MAX_FIRST = 1'b0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         enq,
  input  logic                         deq,
  input  logic [KEY_BITS+VAL_BITS-1:0] kvi,
  output logic [KEY_BITS+VAL_BITS-1:0] kvo,
  output logic                         empty,
  output logic                         full,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         err
);
  localparam int W  = KEY_BITS + VAL_BITS + 1;
  localparam int CW = $clog2(DEPTH+1);
  op_t op;
  logic [DEPTH+1:0][W-1:0] c;
  // deq on empty with enq degrades to a plain enqueue; enq on full without deq is dropped
  always_comb
    op = (enq && deq && !empty) ? OP_REPL :
         (enq && !full)         ? OP_ENQ  :
         (deq && !empty)        ? OP_DEQ  : OP_NONE;
  assign c[0]       = '0;
  assign c[DEPTH+1] = '0;
  for (genvar i = 0; i < DEPTH; i++) begin : g_cell
    srp_cell #(
      .KEY_BITS (KEY_BITS),
      .VAL_BITS (VAL_BITS),
      .MAX_FIRST(MAX_FIRST),
      .FIRST    (i == 0)
    ) u_cell (
      .clk  (clk),
      .rst_n(rst_n),
      .op   (op),
      .kvi  (kvi),
      .left (c[i]),
      .right(c[i+2]),
      .cur  (c[i+1])
    );
  end
  assign kvo   = c[1][W-2:0];
  assign empty = count == '0;
  assign full  = count == CW'(DEPTH);
  // occupancy tracks accepted operations only, so it cannot wrap
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      count <= '0;
      err   <= 1'b0;
    end else begin
      count <= op == OP_ENQ ? count + 1'b1 : op == OP_DEQ ? count - 1'b1 : count;
      err   <= (enq && !deq && full) || (deq && empty);
    end
endmodule

// File: tb/tb_srp_pq.sv
// tb_srp_pq: random and directed checks of min- and max-first queues against a queue model
module tb_srp_pq;
  logic clk = 0, rst_n = 0, enq = 0, deq = 0;
  logic [15:0] kvi = 0;
  logic [15:0] kvo0, kvo1;
  logic e0, e1, f0, f1, r0, r1;
  logic [2:0] c0, c1;
  logic [15:0] q0[$], q1[$];
  logic xerr0 = 0, xerr1 = 0;
  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  srp_pq #(.KEY_BITS(8), .VAL_BITS(8), .DEPTH(4), .MAX_FIRST(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .enq(enq), .deq(deq), .kvi(kvi),
    .kvo(kvo0), .empty(e0), .full(f0), .count(c0), .err(r0));
  srp_pq #(.KEY_BITS(8), .VAL_BITS(8), .DEPTH(4), .MAX_FIRST(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .enq(enq), .deq(deq), .kvi(kvi),
    .kvo(kvo1), .empty(e1), .full(f1), .count(c1), .err(r1));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit outranks(input logic [7:0] a, input logic [7:0] b, input bit maxf);
    return maxf ? (a > b) : (a < b);
  endfunction

  task automatic model(input int m);
    logic [15:0] t[$];
    logic xe;
    int p, n;
    if (m == 1) t = q1; else t = q0;
    n = t.size();
    xe = (enq && !deq && n == 4) || (deq && n == 0);
    if (deq && n > 0) void'(t.pop_front());
    if (enq && (deq || n < 4)) begin
      p = t.size();
      for (int i = t.size() - 1; i >= 0; i--)
        if (outranks(kvi[15:8], t[i][15:8], m == 1)) p = i;
      t.insert(p, kvi);
    end
    if (m == 1) begin q1 = t; xerr1 = xe; end
    else begin q0 = t; xerr0 = xe; end
  endtask

  function automatic logic [15:0] head(input int m);
    if (m == 1) return q1.size() > 0 ? q1[0] : 16'h0;
    return q0.size() > 0 ? q0[0] : 16'h0;
  endfunction

  task automatic check_all();
    check("min_kvo", 32'(kvo0), 32'(head(0)));
    check("min_count", 32'(c0), 32'(q0.size()));
    check("min_empty", 32'(e0), 32'(q0.size() == 0));
    check("min_full", 32'(f0), 32'(q0.size() == 4));
    check("min_err", 32'(r0), 32'(xerr0));
    check("max_kvo", 32'(kvo1), 32'(head(1)));
    check("max_count", 32'(c1), 32'(q1.size()));
    check("max_empty", 32'(e1), 32'(q1.size() == 0));
    check("max_full", 32'(f1), 32'(q1.size() == 4));
    check("max_err", 32'(r1), 32'(xerr1));
  endtask

  task automatic step(input bit e, input bit d, input logic [7:0] k, input logic [7:0] v);
    enq = e; deq = d; kvi = {k, v};
    model(0);
    model(1);
    @(posedge clk);
    #1;
    enq = 0; deq = 0;
    check_all();
  endtask

  task automatic drain();
    for (int i = 0; i < 8 && q0.size() > 0; i++) step(0, 1, 0, 0);
  endtask

  initial begin
    #12 rst_n = 1;
    check_all();
    // sorted insert then ordered drain
    step(1, 0, 30, 0); step(1, 0, 10, 0); step(1, 0, 20, 0);
    check("s1_head", 32'(kvo0[15:8]), 10);
    check("s1_count", 32'(c0), 3);
    drain();
    check("s1_empty_kvo", 32'(kvo0), 0);
    // full, rejected enqueue, replace
    step(1, 0, 5, 0); step(1, 0, 7, 0); step(1, 0, 9, 0); step(1, 0, 11, 0);
    check("s2_full", 32'(f0), 1);
    step(1, 0, 3, 0);
    check("s2_err", 32'(r0), 1);
    step(0, 0, 0, 0);
    check("s2_err_clear", 32'(r0), 0);
    step(1, 1, 8, 0);
    check("s2_repl_head", 32'(kvo0[15:8]), 7);
    check("s2_repl_count", 32'(c0), 4);
    drain();
    // FIFO among equal keys
    step(1, 0, 4, 1); step(1, 0, 4, 2); step(1, 0, 4, 3);
    for (int i = 1; i <= 3; i++) begin
      check("s3_tie_val", 32'(kvo0[7:0]), 32'(i));
      step(0, 1, 0, 0);
    end
    // deq on empty, alone and with enq
    step(0, 1, 0, 0);
    check("s4_err", 32'(r0), 1);
    step(1, 1, 6, 0);
    check("s4_count", 32'(c0), 1);
    check("s4_head", 32'(kvo0[15:8]), 6);
    drain();
    // max-first ordering
    step(1, 0, 2, 0); step(1, 0, 9, 0); step(1, 0, 5, 0);
    check("s5_max_head", 32'(kvo1[15:8]), 9);
    drain();
    // asynchronous reset mid-cycle
    step(1, 0, 3, 0); step(1, 0, 1, 0); step(1, 0, 2, 0);
    #3 rst_n = 0;
    q0.delete(); q1.delete(); xerr0 = 0; xerr1 = 0;
    #1 check_all();
    #2 rst_n = 1;
    step(1, 0, 1, 0);
    check("s6_count", 32'(c0), 1);
    drain();
    // random traffic including illegal requests and many ties
    for (int i = 0; i < 600; i++)
      step(($urandom % 3) != 0, ($urandom % 2) == 1, 8'($urandom_range(0, 15)), 8'($urandom));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
